// File: rtl/nibble_out_responder_if.sv
// CPU-side nibble port and host-side byte stream for nibble_out_responder.
interface nibble_out_responder_if;
    logic [3:0] cpu_data;
    logic [3:0] cpu_ctrl;
    logic [3:0] cpu_status;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ready;

    // Driver side: the CPU output ports plus the host consumer
    modport master (
        output cpu_data,
        output cpu_ctrl,
        output host_ready,
        input  cpu_status,
        input  host_data,
        input  host_valid
    );

    // Responder side
    modport slave (
        input  cpu_data,
        input  cpu_ctrl,
        input  host_ready,
        output cpu_status,
        output host_data,
        output host_valid
    );
endinterface

// File: rtl/nibble_out_responder.sv
// Nibble-to-byte responder: assembles CPU nibble writes into bytes,
// buffers them in a FIFO and drains them over a valid/ready host port.
module nibble_out_responder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    nibble_out_responder_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic             r_strobe_q;
    logic             r_ack;
    logic [3:0]       r_low_nibble;
    logic             r_low_pending;
    logic             r_overflow;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_host_data;

    logic             w_event;
    logic             w_half;
    logic             w_flush;
    logic             w_full;
    logic             w_empty;
    logic             w_valid;
    logic             w_pop;
    logic             w_lo_evt;
    logic             w_hi_evt;
    logic             w_push;
    logic             w_drop;
    logic [7:0]       w_byte;
    logic [PTR_W-1:0] w_rd_inc;
    logic [CNT_W-1:0] w_count_next;
    logic [7:0]       w_head_next;
    logic             w_unused_ctrl3;

    assign w_event  = bus.cpu_ctrl[0] ^ r_strobe_q;
    assign w_half   = bus.cpu_ctrl[1];
    assign w_flush  = bus.cpu_ctrl[2];
    assign w_unused_ctrl3 = bus.cpu_ctrl[3];

    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_valid  = !w_empty && !w_flush;
    assign w_pop    = w_valid && bus.host_ready;

    assign w_lo_evt = w_event && !w_half && !w_flush;
    assign w_hi_evt = w_event &&  w_half && !w_flush;
    assign w_byte   = {bus.cpu_data, r_low_pending ? r_low_nibble : 4'h0};
    // A full FIFO still accepts the byte when the host frees a slot this cycle
    assign w_push   = w_hi_evt && (!w_full || w_pop);
    assign w_drop   = w_hi_evt && w_full && !w_pop;
    assign w_rd_inc = r_rd_ptr + PTR_W'(1);

    // Next occupancy and next head byte; the head is held in a register so
    // host_data keeps the last byte once the FIFO drains
    always_comb begin
        w_count_next = r_count;
        w_head_next  = r_host_data;
        if (w_flush) begin
            w_count_next = '0;
        end else begin
            if (w_push && !w_pop)
                w_count_next = r_count + CNT_W'(1);
            else if (w_pop && !w_push)
                w_count_next = r_count - CNT_W'(1);

            if (w_pop) begin
                if (r_count > CNT_W'(1))
                    w_head_next = r_mem[w_rd_inc];
                else if (w_push)
                    w_head_next = w_byte;
            end else if (w_push && w_empty) begin
                w_head_next = w_byte;
            end
        end
    end

    // Control state, pointers and status bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe_q    <= 1'b0;
            r_ack         <= 1'b0;
            r_low_nibble  <= 4'h0;
            r_low_pending <= 1'b0;
            r_overflow    <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_host_data   <= 8'h00;
        end else begin
            r_strobe_q  <= bus.cpu_ctrl[0];
            r_count     <= w_count_next;
            r_host_data <= w_head_next;
            if (w_event)
                r_ack <= ~r_ack;
            if (w_flush) begin
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_low_pending <= 1'b0;
                r_overflow    <= 1'b0;
            end else begin
                if (w_lo_evt) begin
                    r_low_nibble  <= bus.cpu_data;
                    r_low_pending <= 1'b1;
                end else if (w_hi_evt) begin
                    r_low_pending <= 1'b0;
                end
                if (w_drop)
                    r_overflow <= 1'b1;
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= w_rd_inc;
            end
        end
    end

    // FIFO storage, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (w_push && !reset)
            r_mem[r_wr_ptr] <= w_byte;
    end

    assign bus.cpu_status = {r_overflow, w_empty, w_full, r_ack};
    assign bus.host_valid = w_valid;
    assign bus.host_data  = r_host_data;
endmodule

// File: doc/nibble_out_responder.md
Name: nibble_out_responder

Overview:
- Peripheral-side responder for the Nibbler's output ports: it receives nibbles the CPU writes and presents them to a host as bytes.
- CPU software drives data on OUT_0 and a toggle-strobe/control word on OUT_2. The block acknowledges on IN_2 with a toggle.
- Nibble pairs are assembled into bytes, buffered in a FIFO, and drained through a host-side valid/ready interface.
- Sits beside NIBBLER at top level in the same clock domain.

Parameters:
- FIFO_DEPTH, 8, byte entries in the buffer; power of two, 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_data  input  4  nibble from NIBBLER OUT_0.
- cpu_ctrl  input  4  from NIBBLER OUT_2: [0] strobe toggle, [1] half select (0=low, 1=high), [2] flush level, [3] reserved/ignored.
- cpu_status  output  4  to NIBBLER IN_2: [0] ack toggle, [1] fifo full, [2] fifo empty, [3] overflow sticky.
- host_data  output  8  FIFO head byte; valid only while host_valid=1.
- host_valid  output  1  FIFO non-empty.
- host_ready  input  1  host accepts head byte when host_valid&host_ready at a rising edge.

Behaviour:
- Reset (synchronous, active-high): strobe_q=0, ack=0, low_nibble=0, low_pending=0, overflow=0, FIFO pointers/count=0. Outputs after reset: cpu_status=4'b0100, host_valid=0, host_data=8'h00.
- Edge detect: strobe_q <= cpu_ctrl[0] every cycle. An event is cpu_ctrl[0]!=strobe_q, evaluated in the same cycle. Each CPU toggle yields exactly one event; there is no level sensitivity.
- On event with half=0:
  - low_nibble <= cpu_data, low_pending <= 1.
  - A second low before a high overwrites the first.
- On event with half=1:
  - byte = {cpu_data, low_pending ? low_nibble : 4'h0}; low_pending <= 0.
  - Push byte if FIFO not full, or if full and a pop occurs in the same cycle.
  - Otherwise drop the byte and set overflow <= 1.
- Ack: cpu_status[0] toggles at the same edge on which any event is processed, including dropped pushes and flush-blocked events. Latency: one clock from toggle visible on cpu_ctrl to ack visible.
- Push latency: byte pushed at edge E gives host_valid=1 after E when the FIFO was empty. No fall-through within the same cycle.
- Pop: on host_valid&host_ready, the read pointer advances. host_data shows the next entry, or holds the last value when the FIFO becomes empty.
- Pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH; full is count==FIFO_DEPTH, empty is count==0.
- Simultaneous push and pop:
  - Count unchanged; legal when empty only if push precedes, i.e. with an empty FIFO the pop is ignored (host_valid=0).
  - With a full FIFO, the push is accepted and no overflow occurs.
- Flush: while cpu_ctrl[2]=1, FIFO count/pointers, low_pending and overflow are cleared every cycle.
  - Flush has priority over push and pop; events still toggle ack but push nothing.
  - host_valid=0 while flushing.
- cpu_status[1]/[2] are registered from the post-update count; they reflect the state after each edge.
- Overflow is sticky until flush or reset.
- Reset mid-operation: all state returns to reset values at that edge; pending low nibble and FIFO contents are lost. strobe_q=0, so a CPU strobe held at 1 across reset produces one event on the first post-reset cycle.
- cpu_ctrl[3] is ignored.

Test Plan:
- Basic byte: cpu_data=4'h5 with low toggle, then 4'hA with high toggle -> host_valid=1 one cycle after the second event, host_data=8'hA5. Ack toggles twice (0->1->0). cpu_status empty bit goes 1->0.
- High without low: after reset, cpu_data=4'h3 with half=1 toggle -> host_data=8'h30.
- Fill and overflow (FIFO_DEPTH=8, host_ready=0): push bytes 8'h10..8'h17 -> full=1 after 8th. A 9th pair (8'hFF) is dropped, overflow=1, ack still toggles. Drain with host_ready=1 yields 10..17 in order, then host_valid=0, empty=1.
- Full with simultaneous push/pop: FIFO full, host_ready=1 in the same cycle as a high event with 8'hEE -> overflow stays 0, count stays 8, 8'hEE is last out.
- Flush: 3 bytes buffered, overflow=1, pending low 4'h7. Assert cpu_ctrl[2] for 2 cycles with one toggle during flush -> host_valid=0, status=4'b0100 plus ack toggled. A subsequent high 4'h2 gives 8'h20.
- Reset mid-stream: low 4'h9 pending, 2 bytes buffered, strobe held 1; pulse reset for 1 cycle -> status=4'b0100, host_valid=0. One event is processed on the next cycle: ack=1, and since half holds its last value, either a low is latched or 8'h?0 is pushed.
